div_seq: RTL and testbench



---
 rtl/div_seq.sv | 144 ++++++++++++++
 tb/tb_div_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle.
// A single AdderSuber32 performs every trial subtraction; valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// PREP  | take magnitudes, record result signs, load iteration registers
// ITER  | 32 trial subtractions, one quotient bit each
// FIX   | apply result signs to quotient and remainder
// DONE  | result presented until consumed

module AdderSuber32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result,
  output logic        cout
);
  logic [32:0] sum;

  assign sum    = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
  assign result = sum[31:0];
  assign cout   = sum[32];
endmodule

module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero,
  output logic            busy
);
  if (XLEN != 32) begin : g_xlen_check
    $error("div_seq: XLEN must be 32 to match AdderSuber32");
  end

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t            state;
  logic [XLEN-1:0]   prem;
  logic [XLEN-1:0]   shreg;
  logic [XLEN-1:0]   dvsr;
  logic [4:0]        cnt;
  logic              sgn;
  logic              q_neg;
  logic              r_neg;

  logic [XLEN-1:0]   trial_a;
  logic [XLEN-1:0]   trial_diff;
  logic              trial_ge;

  // Partial remainder never exceeds 31 significant bits before the final
  // iteration, so dropping prem[31] on the shift loses nothing.
  assign trial_a = {prem[XLEN-2:0], shreg[XLEN-1]};

  AdderSuber32 u_addsub (
    .a      (trial_a),
    .b      (dvsr),
    .sub    (1'b1),
    .result (trial_diff),
    .cout   (trial_ge)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prem        <= '0;
      shreg       <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      sgn         <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= dividend;
            dvsr  <= divisor;
            sgn   <= is_signed;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              if (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
                quotient  <= 32'h8000_0000;
                remainder <= '0;
                state     <= DONE;
              end else begin
                state <= PREP;
              end
            end
          end
        end
        PREP: begin
          q_neg <= sgn & (shreg[XLEN-1] ^ dvsr[XLEN-1]);
          r_neg <= sgn & shreg[XLEN-1];
          if (sgn && shreg[XLEN-1]) shreg <= -shreg;
          if (sgn && dvsr[XLEN-1])  dvsr  <= -dvsr;
          prem  <= '0;
          cnt   <= 5'd31;
          state <= ITER;
        end
        ITER: begin
          prem  <= trial_ge ? trial_diff : trial_a;
          shreg <= {shreg[XLEN-2:0], trial_ge};
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          quotient  <= q_neg ? -shreg : shreg;
          remainder <= r_neg ? -prem : prem;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: table of divides with hand-computed results and
// latencies, plus sequences for backpressure, flush and reset mid-operation.

module tb_div_seq;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  div_seq #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and return with the DUT just past the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("%s.out_valid_after", tag), {31'd0, out_valid}, 32'd0);
    chk($sformatf("%s.in_ready_after", tag), {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    chk($sformatf("%s.in_ready_before", tag), {31'd0, in_ready}, 32'd1);
    issue(v.dvd, v.dvs, v.sgn);
    if (v.exp_lat > 1) begin
      chk($sformatf("%s.busy", tag), {31'd0, busy}, 32'd1);
      chk($sformatf("%s.in_ready_busy", tag), {31'd0, in_ready}, 32'd0);
    end
    wait_valid(lat);
    chk($sformatf("%s.latency", tag), lat, v.exp_lat);
    chk($sformatf("%s.quotient", tag), quotient, v.exp_q);
    chk($sformatf("%s.remainder", tag), remainder, v.exp_r);
    chk($sformatf("%s.div_by_zero", tag), {31'd0, div_by_zero}, {31'd0, v.exp_dbz});
    handshake(tag);
  endtask

  initial begin
    int          lat;
    logic [31:0] hold_q, hold_r;
    bit          seen;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 35};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 35};
    vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 35};
    vecs[3]  = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1};
    vecs[5]  = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1};
    vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 35};
    vecs[7]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 35};
    vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0, 35};
    vecs[9]  = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          1'b0, 35};
    vecs[10] = '{32'hDEAD_BEEF,  32'h10,         1'b0, 32'h0DEA_DBEE,  32'hF,          1'b0, 35};
    vecs[11] = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0, 35};
    vecs[12] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 35};

    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
    is_signed = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.quotient", quotient, 32'd0);
    chk("reset.remainder", remainder, 32'd0);
    chk("reset.div_by_zero", {31'd0, div_by_zero}, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 10 cycles, then a new request.
    issue(32'd100, 32'd7, 1'b0);
    wait_valid(lat);
    chk("bp.latency", lat, 35);
    hold_q = 32'd14;
    hold_r = 32'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp.out_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp.quotient_stable", quotient, hold_q);
      chk("bp.remainder_stable", remainder, hold_r);
    end
    handshake("bp");
    run_vec(vecs[12], "bp_next");

    // Flush in ITER cycle 10 (ITER begins at T+2).
    issue(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("flush.busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.busy_after", {31'd0, busy}, 32'd0);
    chk("flush.in_ready_after", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("flush.no_out_valid", {31'd0, seen}, 32'd0);

    // Flush coinciding with an accept discards the request.
    dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept.busy", {31'd0, busy}, 32'd0);

    // Reset mid-ITER returns outputs to reset values.
    issue(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.quotient", quotient, 32'd0);
    chk("rst_mid.remainder", remainder, 32'd0);
    chk("rst_mid.div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    tick();
    run_vec('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 35}, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
